fifo_push_arbiter: RTL
======================

# fifo_push_arbiter

Round-robin burst arbiter that shares the push side of one `basicfifo` instance between `NUM_REQ` producers in the rasteriser front end. Each producer offers words on a valid/ready port; the arbiter grants one owner at a time for a bounded burst and tags every pushed word with the owner's ID. New grants are gated by the FIFO's `almost_full`, and in-burst pushes are gated by `full`.

## Interface
- `WIDTH`, 8, payload width per requester
- `NUM_REQ`, 4, number of requesters (2..16)
- `ID_W`, 2, ID tag width; must equal clog2(`NUM_REQ`)
- `MAX_BURST`, 8, maximum words per grant (1..256)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester word valid
- `req_last`  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid
- `req_data`  in  NUM_REQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high
- `fifo_data`  out  WIDTH+ID_W  word to FIFO `data_in`, laid out as {owner ID, payload}
- `fifo_push`  out  1  to FIFO `push`
- `fifo_full`  in  1  from FIFO `full`
- `fifo_almost_full`  in  1  from FIFO `almost_full`
- `grant_id`  out  ID_W  current owner; valid only while `busy`
- `busy`  out  1  high in BURST state

## Operation
- State machine has two states: IDLE and BURST.
- **IDLE**
  - Stay in IDLE while no requester is valid or `fifo_almost_full` is high.
  - Otherwise, register as owner the first valid index, searching upward from `rr_ptr` with wrap. Clear `beat_cnt` and go to BURST.
  - No transfer happens in this cycle.
- **BURST**
  - `req_ready[owner] = !fifo_full`; all other ready bits are 0.
  - A transfer occurs when `req_valid[owner] && req_ready[owner]`.
  - On a transfer: `fifo_push` = 1, `fifo_data` = {owner, req_data[owner]}, `beat_cnt`++.
- **Release to IDLE.** Any of the following releases the grant; `rr_ptr` then becomes owner+1 mod NUM_REQ:
  - a transfer with `req_last[owner]` high;
  - a transfer with `beat_cnt == MAX_BURST-1`;
  - a cycle in which `req_valid[owner]` is low (no transfer that cycle).
- **`fifo_full` in BURST.** Stall: no push, no release, no counter change.
- **`fifo_almost_full`.** Ignored inside a burst; the FIFO's full protection covers any overrun.
- **Outputs outside BURST.** `fifo_push`, all `req_ready` bits, and `fifo_data` are 0.
- **`beat_cnt`.** Width is clog2(MAX_BURST)+1. It never wraps, because release occurs at MAX_BURST-1.
- **Reset (asserted at any time, including mid-burst).** State = IDLE, `rr_ptr` = 0, owner = 0, `beat_cnt` = 0. All outputs are 0 immediately. A word presented in the reset cycle is not pushed.

## Timing
- `fifo_push`, `fifo_data` and `req_ready` are combinational from registered state plus `fifo_full`/`req_valid`/`req_data`. There are no combinational paths from `req_last` or `fifo_almost_full` to any output.
- Arbitration latency: the first transfer occurs at the earliest 1 cycle after the requester raises valid.
- Release costs one idle cycle, so peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- `rr_ptr` updates on the release edge. A requester that has just been served has the lowest priority at the next grant.
- Starvation bound: a continuously valid requester is granted within (NUM_REQ-1)·(MAX_BURST+1)+1 cycles, ignoring full/almost_full stalls.

## Structure
- The state encoding (IDLE/BURST) and the ID_W derivation helper go in the shared `mch3d_pkg`.
- Sub-module `rr_pick`: purely combinational. Inputs are a request vector and `rr_ptr`; outputs are the winner index and an any-request flag. It is reusable by other arbiters in the codebase.
- The arbiter instantiates `rr_pick`. It does not instantiate `basicfifo`; the parent wires them together.

## Test plan
- Single requester 2 sends 3 words with last on the 3rd, FIFO empty → 3 pushes tagged ID 2 on consecutive cycles after a 1-cycle grant; then IDLE; `rr_ptr` = 3.
- All 4 requesters continuously valid, no last, MAX_BURST=8 → grant order 0,1,2,3,0; exactly 8 pushes per grant; 1 dead cycle between grants.
- `fifo_full` is asserted for 5 cycles mid-burst of requester 1 → `req_ready[1]` is 0 and there is no push for those 5 cycles; the burst then resumes with `beat_cnt` unchanged.
- `fifo_almost_full` high while IDLE with requesters 0 and 3 valid → no grant until it drops; then requester 0 is granted (`rr_ptr` = 0).
- Owner 3 drops valid mid-burst after 2 words → release on that cycle; the next grant goes to the next valid requester at index ≥ 0.
- `rst` asserted during a burst of requester 1 → all outputs are 0 at once; after deassert, with requesters 1 and 2 valid, requester 1 is granted first (`rr_ptr` reset to 0).

Source files
------------

// File: rtl/mch3d_pkg.sv
// Shared definitions for the rasteriser front-end arbiters: the burst
// FSM state encoding and the requester-ID width helper.
package mch3d_pkg;

    // Burst arbiter states, kept as plain constants for legacy tools.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Width of an index able to address n requesters; a single
    // requester still gets a 1-bit ID so the tag never collapses to zero width.
    function automatic int id_w_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin winner search.
// Returns the first asserted request at or above ptr, wrapping at N,
// and a flag telling whether any request is present at all.
module rr_pick
    import mch3d_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_w_for(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        logic          found_v;
        logic [IW-1:0] idx_v;
        winner  = {IW{1'b0}};
        found_v = 1'b0;
        idx_v   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx_v   = IW'((int'(ptr) + i) % N);
            winner  = (req[idx_v] && !found_v) ? idx_v : winner;
            found_v = found_v | req[idx_v];
        end
        any_req = found_v;
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: shares the push port of one FIFO between NUM_REQ
// producers. One owner at a time is granted for a burst of at most
// MAX_BURST words; every pushed word carries the owner ID in its top bits.
// New grants wait for almost_full to clear; pushes inside a burst wait
// for full to clear.
module fifo_push_arbiter
    import mch3d_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH+ID_W-1:0]    fifo_data,
    output logic                     fifo_push,
    input  logic                     fifo_full,
    input  logic                     fifo_almost_full,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    localparam int               BW        = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0]    LAST_BEAT = BW'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [0:0]       state_r;
    logic [ID_W-1:0]  owner_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [BW-1:0]    beat_cnt_r;

    logic [WIDTH-1:0] data_arr_s [NUM_REQ];
    logic [ID_W-1:0]  winner_s;
    logic             any_s;
    logic             in_burst_s;
    logic             owner_valid_s;
    logic             owner_last_s;
    logic             xfer_s;
    logic             release_s;
    logic [ID_W-1:0]  next_ptr_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr_s[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_r),
        .winner  (winner_s),
        .any_req (any_s)
    );

    // Burst control terms; req_last only feeds the release decision, never an output.
    always_comb begin
        in_burst_s    = (state_r == ST_BURST);
        owner_valid_s = req_valid[owner_r];
        owner_last_s  = req_last[owner_r];
        xfer_s        = in_burst_s && owner_valid_s && !fifo_full;
        // A full FIFO freezes the burst entirely, including the valid-drop release.
        release_s     = in_burst_s && !fifo_full &&
                        (!owner_valid_s || owner_last_s || (beat_cnt_r == LAST_BEAT));
        next_ptr_s    = (owner_r == LAST_ID) ? {ID_W{1'b0}} : owner_r + 1'b1;
    end

    // Push-side outputs: only the owner sees ready, data is zero unless pushing.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        fifo_data = {(WIDTH + ID_W){1'b0}};
        if (in_burst_s && !fifo_full) begin
            req_ready[owner_r] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        if (xfer_s) begin
            fifo_data = {owner_r, data_arr_s[owner_r]};
        end else begin
            fifo_data = {(WIDTH + ID_W){1'b0}};
        end
    end

    assign fifo_push = xfer_s;
    assign busy      = in_burst_s;
    assign grant_id  = owner_r;

    // Grant/burst state machine with round-robin pointer and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= {ID_W{1'b0}};
            rr_ptr_r   <= {ID_W{1'b0}};
            beat_cnt_r <= {BW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s && !fifo_almost_full) begin
                        state_r    <= ST_BURST;
                        owner_r    <= winner_s;
                        beat_cnt_r <= {BW{1'b0}};
                    end
                end
                ST_BURST: begin
                    if (xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + 1'b1;
                    end
                    if (release_s) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= next_ptr_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
